synapse_current_driver: RTL

//  Weighted synaptic input stage that sits directly upstream of the LIF neuron
//  and drives its 8-bit `current` input.
//  - Samples NUM_INPUTS presynaptic spike lines each cycle.
//  - Adds the programmable 8-bit weight of every active line.
//  - Saturates the result to 8 bits and holds it in a synaptic-current register.
//  - Weights are written through a simple addressed write port.

---
 rtl/synapse_current_driver.sv | 97 +++++++++
 1 files changed

// File: rtl/synapse_current_driver.sv
// Weighted synaptic input stage: sums the weights of active spike lines and saturates to 8 bits.
// Define SYN_DECAY_EN for a leaky synaptic trace; the default build is memoryless.
module synapse_current_driver #(
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned AW          = 2,
    parameter int unsigned DECAY_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_INPUTS-1:0] spike_in,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [7:0]            cfg_weight,
    output logic [7:0]            current,
    output logic                  sat
);

    localparam int unsigned SW = 8 + $clog2(NUM_INPUTS);
    localparam int unsigned TW = SW + 1;

    logic [7:0]            w [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] spike_q;
    logic [SW-1:0]         sum;
    logic [7:0]            base;
    logic [TW-1:0]         total;
    logic [7:0]            current_next;
    logic                  sat_next;

    // Weight bank; addresses at or beyond NUM_INPUTS match no entry and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                w[i] <= 8'd0;
            end
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (32'(cfg_addr) == i) begin
                    w[i] <= cfg_weight;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_q <= '0;
        end else begin
            spike_q <= enable ? spike_in : '0;
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (spike_q[i]) begin
                sum = sum + SW'(w[i]);
            end
        end
    end

`ifdef SYN_DECAY_EN
    logic [7:0] shifted;
    logic [7:0] dec;

    // Minimum decrement of 1 guarantees a nonzero trace always drains to 0.
    always_comb begin
        shifted = current >> DECAY_SHIFT;
        dec     = shifted;
        if (shifted == 8'd0 && current != 8'd0) begin
            dec = 8'd1;
        end
        base = current - dec;
    end
`else
    assign base = 8'd0;
`endif

    always_comb begin
        total        = TW'(base) + TW'(sum);
        sat_next     = total > TW'(255);
        current_next = sat_next ? 8'hFF : total[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current <= 8'd0;
            sat     <= 1'b0;
        end else if (enable) begin
            current <= current_next;
            sat     <= sat_next;
        end else begin
            sat     <= 1'b0;
        end
    end

endmodule
